uart_periph: RTL and testbench
==============================

Name: uart_periph

Overview:
Memory-mapped UART peripheral hanging off the data bus decoder in the MEM stage, at the word window 0x40000018–0x40000020.
- Serialises CPU-written bytes onto uart_tx.
- Deserialises uart_rx into a receive buffer.
- Exposes status/control bits and an interrupt request line.
- Responds only when the bus decode hits its window; all other addresses are ignored.

Parameters:
CLK_FREQ, 100000000, system clock frequency in Hz
BAUD, 9600, line rate in bit/s; TX divider = CLK_FREQ/BAUD, RX oversample divider = CLK_FREQ/(BAUD*16), both integer-truncated
BASE_ADDR, 32'h40000018, address of first register; registers at +0 (TXD), +4 (RXD), +8 (CON)

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
addr  in  32  byte address from MEM stage
Mem_rd  in  1  read strobe, one cycle per access
Mem_wr  in  1  write strobe, one cycle per access
Write_data  in  32  store data
Read_data  out  32  load data, combinational
uart_rx  in  1  asynchronous serial input
uart_tx  out  1  serial output, idle high
irq  out  1  interrupt request, level

Behaviour:
Interface fact: one clock (clk); reset is synchronous and active-high (reset).

Reset values:
- uart_tx=1, irq=0, all CON bits 0, TXD/RXD data 0.
- TX and RX FSMs to IDLE; dividers to 0.

Register map, hit = Mem_rd|Mem_wr with addr equal to one of the three words:
- TXD (+0), write: Write_data[7:0] queued for transmit. Read returns {24'b0, last written byte}.
- RXD (+4), read: {24'b0, rx_data}. Read clears rx_ready on that edge. Writes ignored.
- CON (+8): bit0 tx_irq_en (RW), bit1 rx_irq_en (RW), bit2 tx_done (RO, sticky), bit3 rx_ready (RO), bit4 tx_busy (RO), bit5 rx_overrun (RO, sticky), bit6 rx_frame_err (RO, sticky), bits[31:7]=0.
  - Write updates bits[1:0] only.
  - Read clears bits 2, 5, 6 on that edge; Read_data shows pre-clear values.

Read_data: combinational; 0 when Mem_rd=0 or no hit.

TX FSM (IDLE, START, DATA, STOP):
- TXD write in IDLE: latch byte; tx_busy=1 on the same edge; uart_tx drives start bit (0) from the next cycle.
- Each bit lasts exactly CLK_FREQ/BAUD cycles. Order: start, 8 data bits LSB first, stop (1).
- End of stop bit: back to IDLE, tx_busy=0, tx_done=1.
- TXD write while tx_busy=1: dropped silently; no state or data change.

RX path:
- uart_rx passes a 2-flop synchroniser.
- IDLE: a falling edge starts the x16 tick counter.
- START: after 8 ticks, sample. Still 0 → DATA; otherwise false start → IDLE.
- DATA: sample every 16 ticks, 8 bits LSB first.
- STOP: sample after 16 ticks.
  - Sample = 1: rx_data ← byte, rx_ready=1. If rx_ready was already 1, also set rx_overrun=1 (new byte overwrites).
  - Sample = 0: set rx_frame_err=1, discard byte, rx_ready unchanged.
- Returns to IDLE in either case; the next falling edge can be detected one cycle later.

Simultaneous events:
- Set beats clear: RX completion on the same edge as an RXD read leaves rx_ready=1 with the new byte.
- TX completion or error on the same edge as a CON read leaves the sticky bit set.

irq: combinational, (tx_irq_en & tx_done) | (rx_irq_en & rx_ready).

Reset mid-frame: both FSMs abort; uart_tx=1 on the next cycle; the partial RX byte is discarded.

Decomposition:
- Package uart_pkg: register offsets (TXD_OFS=0, RXD_OFS=4, CON_OFS=8); CON bit-index constants; TX and RX state encodings; divider-width function.
- One sub-module, uart_baud_gen:
  - Free-running counters producing a 1-cycle tx_tick (restarted on TX start) and rx_tick16 (restarted on RX start edge).
  - Parameterised by CLK_FREQ and BAUD.

Test Plan:
Bench parameters: CLK_FREQ=1600000, BAUD=100000, so 16 cycles/bit and rx_tick16 every cycle.
1. Reset → uart_tx=1, irq=0; read CON at 0x40000020 returns 0x00000000.
2. Write 0xA5 to 0x40000018 → CON.tx_busy=1 next cycle; uart_tx shows 0,1,0,1,0,0,1,0,1,1, each held 16 cycles; then tx_busy=0, tx_done=1. With tx_irq_en set, irq=1; a CON read clears tx_done and irq.
3. Write 0x11 then 0x22 while busy → only 0x11 appears on the line; TXD read returns 0x11.
4. Drive frame 0x3C on uart_rx → rx_ready=1. RXD read returns 0x0000003C and clears rx_ready. A second unread frame 0x5A after 0x3C sets rx_overrun; RXD reads 0x5A.
5. Frame with stop bit 0 → rx_frame_err=1, rx_ready stays 0. A 4-cycle low glitch gives no reception.
6. Assert reset at TX bit 4 → uart_tx=1 next cycle, tx_busy=0; a new TXD write after reset transmits a full clean frame.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared register offsets, CON bit positions, FSM encodings and divider sizing for the UART.
// Latency: n/a (constants and a pure function only).
// Backpressure: n/a.
package uart_pkg;

    // Word offsets from the peripheral base address
    localparam logic [31:0] TXD_OFS = 32'h0000_0000;
    localparam logic [31:0] RXD_OFS = 32'h0000_0004;
    localparam logic [31:0] CON_OFS = 32'h0000_0008;

    // CON register bit positions
    localparam int CON_TX_IRQ_EN    = 0;
    localparam int CON_RX_IRQ_EN    = 1;
    localparam int CON_TX_DONE      = 2;
    localparam int CON_RX_READY     = 3;
    localparam int CON_TX_BUSY      = 4;
    localparam int CON_RX_OVERRUN   = 5;
    localparam int CON_RX_FRAME_ERR = 6;
    localparam int CON_BITS         = 7;

    typedef enum logic [1:0] {
        TX_IDLE  = 2'd0,
        TX_START = 2'd1,
        TX_DATA  = 2'd2,
        TX_STOP  = 2'd3
    } tx_state_e;

    typedef enum logic [1:0] {
        RX_IDLE  = 2'd0,
        RX_START = 2'd1,
        RX_DATA  = 2'd2,
        RX_STOP  = 2'd3
    } rx_state_e;

    // Bits needed for a counter running 0..div-1; never narrower than 1 bit
    function automatic int div_width(input int div);
        if (div <= 2) begin
            return 1;
        end
        return $clog2(div);
    endfunction

endpackage

// File: rtl/uart_baud_gen.sv
// Bit-rate tick generator: tx_tick once per bit period, rx_tick16 at 16x the bit rate.
// Latency: first tick DIV cycles after a restart; each tick is a 1-cycle pulse.
// Backpressure: none; counters free-run and only realign on the restart inputs.
module uart_baud_gen
    import uart_pkg::*;
#(
    parameter int CLK_FREQ = 100000000,
    parameter int BAUD     = 9600
) (
    input  logic clk_i,
    input  logic reset_i,
    input  logic tx_restart_i,
    input  logic rx_restart_i,
    output logic tx_tick_o,
    output logic rx_tick16_o
);

    // Truncated dividers, clamped so a too-fast baud still yields a legal counter
    localparam int TX_DIV_RAW = CLK_FREQ / BAUD;
    localparam int RX_DIV_RAW = CLK_FREQ / (BAUD * 16);
    localparam int TX_DIV     = (TX_DIV_RAW < 1) ? 1 : TX_DIV_RAW;
    localparam int RX_DIV     = (RX_DIV_RAW < 1) ? 1 : RX_DIV_RAW;
    localparam int TX_W       = div_width(TX_DIV);
    localparam int RX_W       = div_width(RX_DIV);
    localparam logic [TX_W-1:0] TX_LAST = TX_W'(TX_DIV - 1);
    localparam logic [RX_W-1:0] RX_LAST = RX_W'(RX_DIV - 1);

    logic [TX_W-1:0] tx_cnt_q;
    logic [RX_W-1:0] rx_cnt_q;

    // TX bit-period counter, realigned to the start of each transmitted frame
    always_ff @(posedge clk_i) begin
        if (reset_i || tx_restart_i) begin
            tx_cnt_q <= '0;
        end else if (tx_cnt_q == TX_LAST) begin
            tx_cnt_q <= '0;
        end else begin
            tx_cnt_q <= tx_cnt_q + TX_W'(1);
        end
    end

    // RX oversample counter, realigned to the detected start edge
    always_ff @(posedge clk_i) begin
        if (reset_i || rx_restart_i) begin
            rx_cnt_q <= '0;
        end else if (rx_cnt_q == RX_LAST) begin
            rx_cnt_q <= '0;
        end else begin
            rx_cnt_q <= rx_cnt_q + RX_W'(1);
        end
    end

    assign tx_tick_o   = (tx_cnt_q == TX_LAST);
    assign rx_tick16_o = (rx_cnt_q == RX_LAST);

endmodule

// File: rtl/uart_periph.sv
// Memory-mapped UART: TXD/RXD/CON word registers, 8N1 transmitter and 16x-oversampled receiver.
// Latency: Read_data combinational; line drives start bit the cycle after a TXD write.
// Backpressure: TXD writes while busy are dropped; an unread RX byte is overwritten (overrun).
module uart_periph
    import uart_pkg::*;
#(
    parameter int          CLK_FREQ  = 100000000,
    parameter int          BAUD      = 9600,
    parameter logic [31:0] BASE_ADDR = 32'h4000_0018
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] addr,
    input  logic        Mem_rd,
    input  logic        Mem_wr,
    input  logic [31:0] Write_data,
    output logic [31:0] Read_data,
    input  logic        uart_rx,
    output logic        uart_tx,
    output logic        irq
);

    // ---------------- bus decode ----------------
    logic access, sel_txd, sel_rxd, sel_con;
    logic txd_wr, rxd_rd, con_rd, con_wr;

    assign access  = Mem_rd | Mem_wr;
    assign sel_txd = access && (addr == BASE_ADDR + TXD_OFS);
    assign sel_rxd = access && (addr == BASE_ADDR + RXD_OFS);
    assign sel_con = access && (addr == BASE_ADDR + CON_OFS);
    assign txd_wr  = Mem_wr & sel_txd;
    assign rxd_rd  = Mem_rd & sel_rxd;
    assign con_rd  = Mem_rd & sel_con;
    assign con_wr  = Mem_wr & sel_con;

    // Only the low byte of store data is meaningful to this block
    logic unused_wdata;
    assign unused_wdata = ^Write_data[31:8];

    // ---------------- tick generator ----------------
    tx_state_e tx_state_q;
    rx_state_e rx_state_q;
    logic      tx_tick, rx_tick;
    logic      tx_start, rx_fall;
    logic      rx_s1_q, rx_s2_q, rx_prev_q;

    assign tx_start = txd_wr && (tx_state_q == TX_IDLE);
    assign rx_fall  = (rx_state_q == RX_IDLE) && rx_prev_q && !rx_s2_q;

    uart_baud_gen #(
        .CLK_FREQ (CLK_FREQ),
        .BAUD     (BAUD)
    ) u_baud (
        .clk_i        (clk),
        .reset_i      (reset),
        .tx_restart_i (tx_start),
        .rx_restart_i (rx_fall),
        .tx_tick_o    (tx_tick),
        .rx_tick16_o  (rx_tick)
    );

    // ---------------- transmitter ----------------
    logic [7:0] tx_byte_q;
    logic [2:0] tx_bit_q;
    logic       tx_q;
    logic       tx_busy, tx_done_set;

    // TX FSM: start bit, 8 data bits LSB first, stop bit; line is a registered output
    always_ff @(posedge clk) begin
        if (reset) begin
            tx_state_q <= TX_IDLE;
            tx_byte_q  <= 8'h00;
            tx_bit_q   <= 3'd0;
            tx_q       <= 1'b1;
        end else begin
            case (tx_state_q)
                TX_IDLE: begin
                    if (txd_wr) begin
                        tx_byte_q  <= Write_data[7:0];
                        tx_q       <= 1'b0;
                        tx_state_q <= TX_START;
                    end
                end
                TX_START: begin
                    if (tx_tick) begin
                        tx_q       <= tx_byte_q[0];
                        tx_bit_q   <= 3'd0;
                        tx_state_q <= TX_DATA;
                    end
                end
                TX_DATA: begin
                    if (tx_tick) begin
                        if (tx_bit_q == 3'd7) begin
                            tx_q       <= 1'b1;
                            tx_state_q <= TX_STOP;
                        end else begin
                            tx_bit_q <= tx_bit_q + 3'd1;
                            tx_q     <= tx_byte_q[tx_bit_q + 3'd1];
                        end
                    end
                end
                TX_STOP: begin
                    if (tx_tick) begin
                        tx_state_q <= TX_IDLE;
                    end
                end
                default: tx_state_q <= TX_IDLE;
            endcase
        end
    end

    assign uart_tx     = tx_q;
    assign tx_busy     = (tx_state_q != TX_IDLE);
    assign tx_done_set = (tx_state_q == TX_STOP) && tx_tick;

    // ---------------- receiver ----------------
    logic [3:0] rx_tcnt_q;
    logic [2:0] rx_bit_q;
    logic [7:0] rx_shift_q;
    logic [7:0] rx_data_q;
    logic       rx_stop_smp, rx_ok_set, rx_ferr_set;

    // Two-flop synchroniser plus a delayed copy for falling-edge detection; idles high
    always_ff @(posedge clk) begin
        if (reset) begin
            rx_s1_q   <= 1'b1;
            rx_s2_q   <= 1'b1;
            rx_prev_q <= 1'b1;
        end else begin
            rx_s1_q   <= uart_rx;
            rx_s2_q   <= rx_s1_q;
            rx_prev_q <= rx_s2_q;
        end
    end

    // RX FSM: verify start at mid-bit (8 ticks), then sample every 16 ticks
    always_ff @(posedge clk) begin
        if (reset) begin
            rx_state_q <= RX_IDLE;
            rx_tcnt_q  <= 4'd0;
            rx_bit_q   <= 3'd0;
            rx_shift_q <= 8'h00;
            rx_data_q  <= 8'h00;
        end else begin
            case (rx_state_q)
                RX_IDLE: begin
                    if (rx_fall) begin
                        rx_tcnt_q  <= 4'd0;
                        rx_state_q <= RX_START;
                    end
                end
                RX_START: begin
                    if (rx_tick) begin
                        if (rx_tcnt_q == 4'd7) begin
                            rx_tcnt_q  <= 4'd0;
                            rx_bit_q   <= 3'd0;
                            rx_state_q <= rx_s2_q ? RX_IDLE : RX_DATA;
                        end else begin
                            rx_tcnt_q <= rx_tcnt_q + 4'd1;
                        end
                    end
                end
                RX_DATA: begin
                    if (rx_tick) begin
                        if (rx_tcnt_q == 4'd15) begin
                            rx_tcnt_q  <= 4'd0;
                            rx_shift_q <= {rx_s2_q, rx_shift_q[7:1]};
                            if (rx_bit_q == 3'd7) begin
                                rx_state_q <= RX_STOP;
                            end else begin
                                rx_bit_q <= rx_bit_q + 3'd1;
                            end
                        end else begin
                            rx_tcnt_q <= rx_tcnt_q + 4'd1;
                        end
                    end
                end
                RX_STOP: begin
                    if (rx_tick) begin
                        if (rx_tcnt_q == 4'd15) begin
                            rx_tcnt_q  <= 4'd0;
                            rx_state_q <= RX_IDLE;
                            if (rx_s2_q) begin
                                rx_data_q <= rx_shift_q;
                            end
                        end else begin
                            rx_tcnt_q <= rx_tcnt_q + 4'd1;
                        end
                    end
                end
                default: rx_state_q <= RX_IDLE;
            endcase
        end
    end

    assign rx_stop_smp = (rx_state_q == RX_STOP) && rx_tick && (rx_tcnt_q == 4'd15);
    assign rx_ok_set   = rx_stop_smp && rx_s2_q;
    assign rx_ferr_set = rx_stop_smp && !rx_s2_q;

    // ---------------- status / control ----------------
    logic tx_irq_en_q, rx_irq_en_q;
    logic tx_done_q, rx_ready_q, rx_ovr_q, rx_ferr_q;

    // Control bits and sticky status; a set on the same edge as a clearing read wins
    always_ff @(posedge clk) begin
        if (reset) begin
            tx_irq_en_q <= 1'b0;
            rx_irq_en_q <= 1'b0;
            tx_done_q   <= 1'b0;
            rx_ready_q  <= 1'b0;
            rx_ovr_q    <= 1'b0;
            rx_ferr_q   <= 1'b0;
        end else begin
            if (con_wr) begin
                tx_irq_en_q <= Write_data[CON_TX_IRQ_EN];
                rx_irq_en_q <= Write_data[CON_RX_IRQ_EN];
            end
            if (tx_done_set) begin
                tx_done_q <= 1'b1;
            end else if (con_rd) begin
                tx_done_q <= 1'b0;
            end
            if (rx_ok_set) begin
                rx_ready_q <= 1'b1;
            end else if (rxd_rd) begin
                rx_ready_q <= 1'b0;
            end
            if (rx_ok_set && rx_ready_q) begin
                rx_ovr_q <= 1'b1;
            end else if (con_rd) begin
                rx_ovr_q <= 1'b0;
            end
            if (rx_ferr_set) begin
                rx_ferr_q <= 1'b1;
            end else if (con_rd) begin
                rx_ferr_q <= 1'b0;
            end
        end
    end

    logic [CON_BITS-1:0] con_vec;

    // Assemble the CON image shown on reads (pre-clear values)
    always_comb begin
        con_vec                   = '0;
        con_vec[CON_TX_IRQ_EN]    = tx_irq_en_q;
        con_vec[CON_RX_IRQ_EN]    = rx_irq_en_q;
        con_vec[CON_TX_DONE]      = tx_done_q;
        con_vec[CON_RX_READY]     = rx_ready_q;
        con_vec[CON_TX_BUSY]      = tx_busy;
        con_vec[CON_RX_OVERRUN]   = rx_ovr_q;
        con_vec[CON_RX_FRAME_ERR] = rx_ferr_q;
    end

    // Load data mux; zero unless a read hits one of our words
    always_comb begin
        Read_data = 32'h0;
        if (Mem_rd) begin
            if (sel_txd) begin
                Read_data = {24'h0, tx_byte_q};
            end else if (sel_rxd) begin
                Read_data = {24'h0, rx_data_q};
            end else if (sel_con) begin
                Read_data = {{(32-CON_BITS){1'b0}}, con_vec};
            end
        end
    end

    assign irq = (tx_irq_en_q & tx_done_q) | (rx_irq_en_q & rx_ready_q);

endmodule

// File: tb/tb_uart_periph.sv
// Self-checking bench for uart_periph against a frame-level behavioural model.
// Latency: n/a.
// Backpressure: n/a.
module tb_uart_periph;

    localparam int          CLK_FREQ = 1600000;
    localparam int          BAUD     = 100000;
    localparam int          BIT_CYC  = 16;
    localparam logic [31:0] A_TXD    = 32'h4000_0018;
    localparam logic [31:0] A_RXD    = 32'h4000_001C;
    localparam logic [31:0] A_CON    = 32'h4000_0020;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] addr;
    logic        Mem_rd, Mem_wr;
    logic [31:0] Write_data;
    logic [31:0] Read_data;
    logic        uart_rx;
    logic        uart_tx;
    logic        irq;

    always #5 clk = ~clk;

    uart_periph #(
        .CLK_FREQ  (CLK_FREQ),
        .BAUD      (BAUD),
        .BASE_ADDR (32'h4000_0018)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .addr       (addr),
        .Mem_rd     (Mem_rd),
        .Mem_wr     (Mem_wr),
        .Write_data (Write_data),
        .Read_data  (Read_data),
        .uart_rx    (uart_rx),
        .uart_tx    (uart_tx),
        .irq        (irq)
    );

    int checks   = 0;
    int failures = 0;

    // Behavioural model of the register-visible state
    bit         m_txen, m_rxen, m_done, m_ready, m_ovr, m_ferr;
    logic [7:0] m_rxdata, m_txbyte;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] con_exp(input bit busy);
        return {25'b0, m_ferr, m_ovr, busy, m_ready, m_done, m_rxen, m_txen};
    endfunction

    task automatic model_reset();
        m_txen = 0; m_rxen = 0; m_done = 0; m_ready = 0; m_ovr = 0; m_ferr = 0;
        m_rxdata = 8'h00; m_txbyte = 8'h00;
    endtask

    task automatic bus_write(input logic [31:0] a, input logic [31:0] d);
        @(negedge clk);
        addr = a; Write_data = d; Mem_wr = 1'b1;
        @(negedge clk);
        Mem_wr = 1'b0; addr = 32'h0; Write_data = 32'h0;
    endtask

    task automatic bus_read(input logic [31:0] a, output logic [31:0] d);
        @(negedge clk);
        addr = a; Mem_rd = 1'b1;
        #1 d = Read_data;
        @(negedge clk);
        Mem_rd = 1'b0; addr = 32'h0;
    endtask

    task automatic read_con_check(input string tag, input bit busy);
        logic [31:0] v;
        bus_read(A_CON, v);
        check_val(tag, v, con_exp(busy));
        m_done = 0; m_ovr = 0; m_ferr = 0;
    endtask

    task automatic read_rxd_check(input string tag);
        logic [31:0] v;
        bus_read(A_RXD, v);
        check_val(tag, v, {24'h0, m_rxdata});
        m_ready = 0;
    endtask

    task automatic write_con(input logic [1:0] en);
        bus_write(A_CON, {30'h0, en});
        m_txen = en[0]; m_rxen = en[1];
    endtask

    task automatic write_txd(input logic [7:0] b, input bit accepted);
        bus_write(A_TXD, {24'h0, b});
        if (accepted) m_txbyte = b;
    endtask

    task automatic check_irq(input string tag);
        check_val(tag, {31'h0, irq}, {31'h0, (m_txen & m_done) | (m_rxen & m_ready)});
    endtask

    // Expects the line to carry {stop, byte, start}, every cycle of every bit
    task automatic tx_frame(input logic [7:0] b);
        logic [9:0] fr;
        fr = {1'b1, b, 1'b0};
        for (int i = 0; i < 10 * BIT_CYC; i++) begin
            check_val($sformatf("tx_bit%0d_cyc%0d", i / BIT_CYC, i % BIT_CYC),
                      {31'h0, uart_tx}, {31'h0, fr[i / BIT_CYC]});
            @(negedge clk);
        end
        m_done = 1;
    endtask

    // Drives one serial frame and updates the model with its outcome
    task automatic rx_send(input logic [7:0] b, input bit stop_ok);
        logic [9:0] fr;
        fr = {stop_ok, b, 1'b0};
        for (int i = 0; i < 10; i++) begin
            uart_rx = fr[i];
            repeat (BIT_CYC) @(negedge clk);
        end
        uart_rx = 1'b1;
        repeat (20) @(negedge clk);
        if (stop_ok) begin
            if (m_ready) m_ovr = 1;
            m_ready  = 1;
            m_rxdata = b;
        end else begin
            m_ferr = 1;
        end
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [31:0] v;
        logic [7:0]  b;
        reset = 1'b1; Mem_rd = 1'b0; Mem_wr = 1'b0; addr = 32'h0;
        Write_data = 32'h0; uart_rx = 1'b1;
        model_reset();
        repeat (3) @(negedge clk);
        check_val("reset_tx", {31'h0, uart_tx}, 32'h1);
        check_val("reset_irq", {31'h0, irq}, 32'h0);
        reset = 1'b0;
        read_con_check("reset_con", 0);

        // Transmit 0xA5 with TX interrupt enabled
        write_con(2'b01);
        write_txd(8'hA5, 1);
        fork
            tx_frame(8'hA5);
            read_con_check("busy_con", 1);
        join
        check_irq("tx_irq_set");
        read_con_check("tx_done_con", 0);
        check_irq("tx_irq_clr");

        // Write while busy is dropped
        write_txd(8'h11, 1);
        fork
            tx_frame(8'h11);
            begin
                repeat (30) @(negedge clk);
                write_txd(8'h22, 0);
            end
        join
        bus_read(A_TXD, v);
        check_val("txd_readback", v, {24'h0, m_txbyte});
        read_con_check("drop_con", 0);

        // Receive, read, then overrun
        write_con(2'b10);
        rx_send(8'h3C, 1);
        check_irq("rx_irq_set");
        read_con_check("rx_ready_con", 0);
        read_rxd_check("rxd_3c");
        read_con_check("rx_clr_con", 0);
        check_irq("rx_irq_clr");
        rx_send(8'h3C, 1);
        rx_send(8'h5A, 1);
        read_con_check("ovr_con", 0);
        read_rxd_check("rxd_5a");
        read_con_check("ovr_clr_con", 0);

        // Framing error and short glitch
        rx_send(8'($urandom), 0);
        read_con_check("ferr_con", 0);
        uart_rx = 1'b0;
        repeat (4) @(negedge clk);
        uart_rx = 1'b1;
        repeat (40) @(negedge clk);
        read_con_check("glitch_con", 0);
        read_rxd_check("glitch_rxd");

        // Random RX traffic with random reads
        write_con(2'($urandom));
        for (int k = 0; k < 8; k++) begin
            b = 8'($urandom);
            rx_send(b, $urandom_range(0, 3) != 0);
            check_irq($sformatf("rnd_rx_irq%0d", k));
            case ($urandom_range(0, 2))
                0: read_rxd_check($sformatf("rnd_rxd%0d", k));
                1: read_con_check($sformatf("rnd_con%0d", k), 0);
                default: ;
            endcase
        end
        read_con_check("rnd_rx_final_con", 0);
        read_rxd_check("rnd_rx_final_rxd");

        // Random TX bytes
        for (int k = 0; k < 3; k++) begin
            b = 8'($urandom);
            write_txd(b, 1);
            tx_frame(b);
            repeat ($urandom_range(1, 10)) @(negedge clk);
            check_irq($sformatf("rnd_tx_irq%0d", k));
            read_con_check($sformatf("rnd_tx_con%0d", k), 0);
        end

        // Reset in the middle of a transmission
        b = 8'($urandom);
        write_txd(b, 1);
        repeat (5 * BIT_CYC + 4) @(negedge clk);
        check_val("pre_reset_bit", {31'h0, uart_tx}, {31'h0, b[4]});
        reset = 1'b1;
        @(negedge clk);
        check_val("mid_reset_tx", {31'h0, uart_tx}, 32'h1);
        reset = 1'b0;
        model_reset();
        read_con_check("post_reset_con", 0);
        bus_read(A_TXD, v);
        check_val("post_reset_txd", v, {24'h0, m_txbyte});
        b = 8'($urandom);
        write_txd(b, 1);
        tx_frame(b);
        read_con_check("post_reset_done", 0);
        check_val("idle_tx", {31'h0, uart_tx}, 32'h1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
